spi_stream_arbiter: RTL and testbench

//  Shares one spi_master byte-stream port between two requesters (e.g. CPU SPI

---
 rtl/spi_stream_arbiter.sv | 139 +++++++++++++
 tb/tb_spi_stream_arbiter.sv | 539 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_stream_arbiter.sv
// Two-requester packet arbiter in front of one spi_master byte port.
// Round-robin per packet, one byte in flight, idle gap between packets.
module spi_stream_arbiter #(
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [1:0] grant,
    output logic       busy
);

    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        DRAIN,
        REFILL,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [7:0]    m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic          last_q, last_d;
    logic          rr_q, rr_d;
    logic [GW-1:0] gap_q, gap_d;

    logic       own_valid;
    logic [7:0] own_data;
    logic       own_last;

    assign own_valid = grant_q[1] ? req1_valid : req0_valid;
    assign own_data  = grant_q[1] ? req1_data  : req0_data;
    assign own_last  = grant_q[1] ? req1_last  : req0_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            last_q    <= 1'b0;
            rr_q      <= 1'b0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            last_q    <= last_d;
            rr_q      <= rr_d;
            gap_q     <= gap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        last_d    = last_q;
        rr_d      = rr_q;
        gap_d     = gap_q;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    if (req0_valid && req1_valid)
                        grant_d = rr_q ? 2'b10 : 2'b01;
                    else
                        grant_d = req1_valid ? 2'b10 : 2'b01;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (own_valid) begin
                    m_data_d  = own_data;
                    last_d    = own_last;
                    m_valid_d = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = DRAIN;
                end
            end
            // master ready is registered and may still read high right after accept
            DRAIN: begin
                if (!m_ready)
                    state_d = REFILL;
            end
            REFILL: begin
                if (m_ready) begin
                    if (last_q) begin
                        state_d = GAP;
                        grant_d = '0;
                        rr_d    = grant_q[0];
                        gap_d   = '0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req0_ready = (state_q == LOAD) && grant_q[0];
    assign req1_ready = (state_q == LOAD) && grant_q[1];
    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign grant      = grant_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_spi_stream_arbiter.sv
// Randomized bench for spi_stream_arbiter: queue-driven requesters, a simple
// spi_master responder and a packet-level round-robin reference model.
module tb_spi_stream_arbiter;

    localparam int unsigned GAP = 4;

    typedef struct {
        logic [7:0]  d;
        logic        l;
        int unsigned dly;
    } byte_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] g;
    } xfer_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req0_data = '0;
    logic       req0_valid = 1'b0;
    logic       req0_last = 1'b0;
    logic       req0_ready;
    logic [7:0] req1_data = '0;
    logic       req1_valid = 1'b0;
    logic       req1_last = 1'b0;
    logic       req1_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [1:0] grant;
    logic       busy;

    spi_stream_arbiter #(.GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_data  (req0_data),
        .req0_valid (req0_valid),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_data  (req1_data),
        .req1_valid (req1_valid),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .grant      (grant),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    byte_t src0[$], src1[$], mdl0[$], mdl1[$];
    xfer_t obs[$], exp_q[$];
    int    tests_run = 0;
    int    tests_failed = 0;
    int    rdy0_cnt = 0;
    int    rdy1_cnt = 0;
    int    model_rr = 0;
    int unsigned bt_max = 1;
    bit    lag_en = 1'b0;
    bit    m_hold = 1'b0;

    // requester 0 source
    initial begin
        byte_t b;
        forever begin
            @(posedge clk); #1;
            if (src0.size() > 0) begin
                b = src0[0];
                if (b.dly > 0) begin
                    b.dly = b.dly - 1;
                    src0[0] = b;
                    req0_valid = 1'b0;
                    req0_data  = 8'($urandom);
                end else begin
                    req0_valid = 1'b1;
                    req0_data  = b.d;
                    req0_last  = b.l;
                end
            end else begin
                req0_valid = 1'b0;
                req0_data  = 8'($urandom);
                req0_last  = 1'($urandom);
            end
        end
    end

    // requester 1 source
    initial begin
        byte_t b;
        forever begin
            @(posedge clk); #1;
            if (src1.size() > 0) begin
                b = src1[0];
                if (b.dly > 0) begin
                    b.dly = b.dly - 1;
                    src1[0] = b;
                    req1_valid = 1'b0;
                    req1_data  = 8'($urandom);
                end else begin
                    req1_valid = 1'b1;
                    req1_data  = b.d;
                    req1_last  = b.l;
                end
            end else begin
                req1_valid = 1'b0;
                req1_data  = 8'($urandom);
                req1_last  = 1'($urandom);
            end
        end
    end

    // spi_master responder: ready drops for a byte time after each accept
    initial begin
        bit acc;
        bit lagp;
        int unsigned cnt;
        lagp = 1'b0;
        cnt  = 0;
        m_ready = 1'b1;
        forever begin
            @(negedge clk);
            acc = m_valid && m_ready && rst_n;
            @(posedge clk); #1;
            if (acc) begin
                cnt = $urandom_range(bt_max, 1);
                if (lag_en && ($urandom_range(1, 0) == 1)) lagp = 1'b1;
                else m_ready = 1'b0;
            end else if (lagp) begin
                lagp = 1'b0;
                m_ready = 1'b0;
            end else if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 0) m_ready = !m_hold;
            end else begin
                m_ready = !m_hold;
            end
        end
    end

    // transfer monitor and stall-stability check
    initial begin
        bit         stall_prev;
        logic [7:0] prev_d;
        stall_prev = 1'b0;
        prev_d = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall_prev) begin
                    tests_run++;
                    if (m_valid !== 1'b1 || m_data !== prev_d) begin
                        tests_failed++;
                        $display("FAIL stall_stable: m_valid=%b m_data=%h, want 1/%h", m_valid, m_data, prev_d);
                    end
                end
                if (m_valid && m_ready) obs.push_back('{m_data, grant});
                if (req0_valid && req0_ready && src0.size() > 0) void'(src0.pop_front());
                if (req1_valid && req1_ready && src1.size() > 0) void'(src1.pop_front());
                rdy0_cnt += int'(req0_ready);
                rdy1_cnt += int'(req1_ready);
            end
            stall_prev = m_valid && !m_ready && rst_n;
            prev_d = m_data;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input int r, input logic [7:0] d, input logic l,
                        input int unsigned dly, input bit to_model);
        byte_t b;
        b = '{d, l, dly};
        if (r == 0) begin
            src0.push_back(b);
            if (to_model) mdl0.push_back(b);
        end else begin
            src1.push_back(b);
            if (to_model) mdl1.push_back(b);
        end
    endtask

    // packet-level round robin over everything queued so far
    task automatic model_run();
        int    owner;
        byte_t b;
        while (mdl0.size() > 0 || mdl1.size() > 0) begin
            if (mdl0.size() > 0 && mdl1.size() > 0) owner = model_rr;
            else owner = (mdl0.size() > 0) ? 0 : 1;
            do begin
                b = (owner == 0) ? mdl0.pop_front() : mdl1.pop_front();
                exp_q.push_back('{b.d, (owner == 0) ? 2'b01 : 2'b10});
            end while (!b.l && ((owner == 0) ? mdl0.size() : mdl1.size()) > 0);
            model_rr = 1 - owner;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        src0.delete(); src1.delete(); mdl0.delete(); mdl1.delete();
        obs.delete(); exp_q.delete();
        model_rr = 0;
        m_hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rdy0_cnt = 0;
        rdy1_cnt = 0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (src0.size() == 0 && src1.size() == 0 && !busy && !m_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        #12;
        tests_run++;
        if ({m_valid, m_data, grant, busy, req0_ready, req1_ready} !== 13'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: v=%b d=%h g=%b busy=%b r0=%b r1=%b, want all 0",
                     m_valid, m_data, grant, busy, req0_ready, req1_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_hold = 1'b1;
        push(0, 8'h77, 1'b1, 0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (m_valid) begin ok = 1'b1; break; end
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL reset_reach_issue: m_valid=%b, want 1 within 30 cycles", m_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (m_valid !== 1'b0 || grant !== 2'b00 || busy !== 1'b0 || m_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_async: v=%b g=%b busy=%b d=%h, want 0/00/0/00", m_valid, grant, busy, m_data);
        end
        src0.delete(); src1.delete(); obs.delete(); exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_hold = 1'b0;
        model_rr = 0;
        push(0, 8'h3C, 1'b1, 0, 1'b1);
        push(1, 8'hC3, 1'b1, 0, 1'b1);
        model_run();
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (grant != 2'b00) begin ok = 1'b1; break; end
        end
        tests_run++;
        if (!ok || grant !== 2'b01) begin
            tests_failed++;
            $display("FAIL reset_first_grant: grant=%b, want 01", grant);
        end
        wait_done(400, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL reset_timeout: busy=%b, want idle", busy); end
        tests_run++;
        if (obs.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL reset_count: got %0d bytes, want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            tests_run++;
            if (obs[i].d !== exp_q[i].d || obs[i].g !== exp_q[i].g) begin
                tests_failed++;
                $display("FAIL reset_byte%0d: got %h/%b want %h/%b", i, obs[i].d, obs[i].g, exp_q[i].d, exp_q[i].g);
            end
        end
    endtask

    task automatic test_single();
        bit ok;
        int gap_seen;
        do_reset();
        bt_max = 3;
        lag_en = 1'b0;
        push(0, 8'hA5, 1'b1, 0, 1'b1);
        model_run();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (busy) begin ok = 1'b1; break; end
        end
        gap_seen = 0;
        for (int i = 0; i < 200 && ok; i++) begin
            @(negedge clk); #1;
            if (!busy) break;
            if (grant == 2'b00) gap_seen++;
        end
        tests_run++;
        if (busy !== 1'b0 || !ok) begin tests_failed++; $display("FAIL single_busy_end: busy=%b, want 0", busy); end
        tests_run++;
        if (gap_seen != GAP) begin
            tests_failed++;
            $display("FAIL single_gap: got %0d gap cycles, want %0d", gap_seen, GAP);
        end
        tests_run++;
        if (rdy0_cnt != 1 || rdy1_cnt != 0) begin
            tests_failed++;
            $display("FAIL single_ready: req0_ready %0d cycles, req1_ready %0d, want 1/0", rdy0_cnt, rdy1_cnt);
        end
        tests_run++;
        if (obs.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL single_count: got %0d bytes, want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            tests_run++;
            if (obs[i].d !== exp_q[i].d || obs[i].g !== exp_q[i].g) begin
                tests_failed++;
                $display("FAIL single_byte%0d: got %h/%b want %h/%b", i, obs[i].d, obs[i].g, exp_q[i].d, exp_q[i].g);
            end
        end
    endtask

    task automatic test_contention();
        bit ok;
        do_reset();
        bt_max = 2;
        lag_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push(0, 8'h01 + 8'(k), k == 2, 0, 1'b1);
            push(1, 8'h11 + 8'(k), k == 2, 0, 1'b1);
        end
        model_run();
        wait_done(500, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL contention_timeout: busy=%b, want idle", busy); end
        tests_run++;
        if (obs.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL contention_count: got %0d bytes, want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            tests_run++;
            if (obs[i].d !== exp_q[i].d || obs[i].g !== exp_q[i].g) begin
                tests_failed++;
                $display("FAIL contention_byte%0d: got %h/%b want %h/%b", i, obs[i].d, obs[i].g, exp_q[i].d, exp_q[i].g);
            end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        bt_max = 3;
        lag_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push(0, 8'hA0 + 8'(k), 1'b1, 0, 1'b1);
            push(1, 8'hB0 + 8'(k), 1'b1, 0, 1'b1);
        end
        model_run();
        wait_done(800, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL rr_timeout: busy=%b, want idle", busy); end
        tests_run++;
        if (obs.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL rr_count: got %0d bytes, want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            tests_run++;
            if (obs[i].d !== exp_q[i].d || obs[i].g !== exp_q[i].g) begin
                tests_failed++;
                $display("FAIL rr_byte%0d: got %h/%b want %h/%b", i, obs[i].d, obs[i].g, exp_q[i].d, exp_q[i].g);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int rdy_snap;
        do_reset();
        bt_max = 2;
        lag_en = 1'b0;
        m_hold = 1'b1;
        push(0, 8'h5A, 1'b0, 0, 1'b1);
        push(0, 8'h5B, 1'b1, 0, 1'b1);
        model_run();
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (m_valid) begin ok = 1'b1; break; end
        end
        rdy_snap = rdy0_cnt;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            tests_run++;
            if (m_valid !== 1'b1 || m_data !== 8'h5A || req0_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: v=%b d=%h r0=%b, want 1/5a/0", i, m_valid, m_data, req0_ready);
            end
        end
        tests_run++;
        if (!ok || rdy0_cnt != rdy_snap || obs.size() != 0) begin
            tests_failed++;
            $display("FAIL bp_no_accept: ready pulses %0d->%0d, sent %0d, want unchanged/0",
                     rdy_snap, rdy0_cnt, obs.size());
        end
        m_hold = 1'b0;
        wait_done(300, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL bp_timeout: busy=%b, want idle", busy); end
        tests_run++;
        if (obs.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d bytes, want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            tests_run++;
            if (obs[i].d !== exp_q[i].d || obs[i].g !== exp_q[i].g) begin
                tests_failed++;
                $display("FAIL bp_byte%0d: got %h/%b want %h/%b", i, obs[i].d, obs[i].g, exp_q[i].d, exp_q[i].g);
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        do_reset();
        bt_max = 2;
        lag_en = 1'b0;
        push(1, 8'h21, 1'b0, 0, 1'b1);
        push(1, 8'h22, 1'b0, 25, 1'b1);
        push(1, 8'h23, 1'b1, 0, 1'b1);
        model_run();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (grant == 2'b10) begin ok = 1'b1; break; end
        end
        push(0, 8'h31, 1'b1, 0, 1'b1);
        model_run();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (obs.size() >= 1) break;
        end
        repeat (6) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            tests_run++;
            if (!ok || grant !== 2'b10 || req1_ready !== 1'b1 || req0_ready !== 1'b0 || req0_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall_load%0d: g=%b r1=%b r0=%b v0=%b, want 10/1/0/1",
                         i, grant, req1_ready, req0_ready, req0_valid);
            end
        end
        wait_done(500, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL stall_timeout: busy=%b, want idle", busy); end
        tests_run++;
        if (obs.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL stall_count: got %0d bytes, want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            tests_run++;
            if (obs[i].d !== exp_q[i].d || obs[i].g !== exp_q[i].g) begin
                tests_failed++;
                $display("FAIL stall_byte%0d: got %h/%b want %h/%b", i, obs[i].d, obs[i].g, exp_q[i].d, exp_q[i].g);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int np;
        int len;
        for (int round = 0; round < 4; round++) begin
            do_reset();
            bt_max = $urandom_range(5, 1);
            lag_en = 1'($urandom);
            for (int r = 0; r < 2; r++) begin
                np = $urandom_range(6, 0);
                for (int p = 0; p < np; p++) begin
                    len = $urandom_range(4, 1);
                    for (int k = 0; k < len; k++)
                        push(r, 8'($urandom), k == len - 1,
                             (k == 0 || $urandom_range(3, 0) != 0) ? 0 : $urandom_range(6, 1), 1'b1);
                end
            end
            model_run();
            wait_done(3000, ok);
            tests_run++;
            if (!ok) begin tests_failed++; $display("FAIL random%0d_timeout: busy=%b, want idle", round, busy); end
            tests_run++;
            if (obs.size() != exp_q.size()) begin
                tests_failed++;
                $display("FAIL random%0d_count: got %0d bytes, want %0d", round, obs.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
                tests_run++;
                if (obs[i].d !== exp_q[i].d || obs[i].g !== exp_q[i].g) begin
                    tests_failed++;
                    $display("FAIL random%0d_byte%0d: got %h/%b want %h/%b",
                             round, i, obs[i].d, obs[i].g, exp_q[i].d, exp_q[i].g);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_round_robin();
        test_backpressure();
        test_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
